coin_payout: RTL and testbench
==============================

// Module: coin_payout
// PURPOSE
//  Change-dispense back end for the vending FSM. Takes the 2-bit change request and pays it out.
//  Drives one ejector solenoid per denomination (5 Rs, 10 Rs) with timed pulses.
//  Tracks the coin inventory held in each tube.
//  Sits between the vending FSM's change output and the coin-hopper drivers.
// PARAMETERS
//  PULSE_CYC   4   eject pulse width in clk cycles (>=1)
//  GAP_CYC     4   idle cycles after each coin before next action (>=1)
//  INV_W       8   inventory counter width
//  INV_INIT5   20  5 Rs tube count loaded at reset/refill
//  INV_INIT10  20  10 Rs tube count loaded at reset/refill
//  CONFIRM_TO  16  drop-confirm timeout in cycles (macro build only)
// PORTS
//  clk         in   1      clock, posedge
//  rst         in   1      synchronous reset, active-high
//  req_valid   in   1      change request valid
//  req_ready   out  1      block can accept a request
//  req_change  in   2      00 none, 01 = 5 Rs, 10 = 10 Rs, 11 = 15 Rs
//  refill      in   1      reload both inventories to INIT values
//  drop_sense  in   1      coin-drop optical sensor (used only with macro)
//  eject5      out  1      5 Rs solenoid drive
//  eject10     out  1      10 Rs solenoid drive
//  busy        out  1      request in progress (state != IDLE)
//  done        out  1      one-cycle pulse: request finished
//  err         out  1      last request not fully paid; held until next accept or rst
//  inv5        out  INV_W  5 Rs coins remaining
//  inv10       out  INV_W  10 Rs coins remaining
//  low         out  1      inv5==0 or inv10==0
// BEHAVIOUR
//  Reset: state IDLE, eject5=eject10=0, done=0, err=0, busy=0, inv5=INV_INIT5, inv10=INV_INIT10.
//   Reset takes effect at the edge, including mid-payout. The plan in progress is discarded.
//  req_ready = (state==IDLE). Accept on req_valid&&req_ready. req_change is latched, err cleared.
//  States: IDLE -> PLAN -> {PULSE -> GAP}* -> DONE -> IDLE.
//  PLAN (1 cycle): amount in 5 Rs units (1..3) is resolved, preferring 10 Rs coins:
//   1: one 5 Rs if inv5>=1, else fail.
//   2: one 10 Rs if inv10>=1; else two 5 Rs if inv5>=2; else fail.
//   3: 10+5 if inv10>=1 and inv5>=1; else three 5 Rs if inv5>=3; else fail.
//   Fail: no coins ejected, err=1, go to DONE.
//   00: go to DONE, err=0.
//  Coin order: the 10 Rs coin first, then 5 Rs coins.
//  PULSE: the selected eject line is high exactly PULSE_CYC cycles. Never both lines high.
//   The matching inventory decrements on the first PULSE cycle (visible next cycle).
//  GAP: both lines low for GAP_CYC cycles, after every coin including the last.
//  DONE: done=1 for 1 cycle, then IDLE.
//  Latency (defaults, accept at cycle 0, one coin): PLAN c1, pulse c2-c5, gap c6-c9, done c10, ready c11.
//   Each extra coin adds PULSE_CYC+GAP_CYC cycles.
//  refill: honoured only in IDLE; ignored otherwise.
//   If refill and accept happen in the same cycle, PLAN uses the refilled counts.
//  Inventories never underflow; the plan check guarantees this.
//  req_valid while busy is ignored (no queuing). The source must hold req_valid until ready.
// CONFIGURATION
//  COIN_PAYOUT_CONFIRM_EN defined:
//   After each PULSE the FSM enters WAIT_DROP and waits for drop_sense==1.
//   drop_sense seen within CONFIRM_TO cycles: go to GAP.
//   Timeout: err=1, remaining coins abandoned, go to DONE. The inventory decrement stands.
//  Macro undefined: no WAIT_DROP state, drop_sense ignored, PULSE goes directly to GAP.
// TESTING
//  T1 reset, req_change=01 -> eject5 high c2-c5, done c10, inv5 20->19, err=0
//  T2 req=11, inv5=inv10=20 -> eject10 4 cycles, gap, eject5 4 cycles; done c18; inv10=19, inv5=19
//  T3 req=10 with inv10 drained to 0 -> two eject5 pulses, inv5 -2, err=0
//  T4 req=11 with inv10=0, inv5=2 -> no eject, done c2, err=1, inventories unchanged
//  T5 rst during second pulse of T2 -> eject lines low next cycle, inv back to 20/20, ready=1
//  T6 (macro) drop_sense held 0 after first pulse -> err=1 and done after CONFIRM_TO cycles;
//     no second coin; inv decremented once

Source files
------------

// File: rtl/coin_payout.sv
// coin_payout: change-dispense back end for the vending FSM.
//   Accepts a 2-bit change request (00 none, 01 5 Rs, 10 10 Rs, 11 15 Rs).
//   Plans the coins to pay, preferring 10 Rs coins, and fires the solenoids
//   with timed pulses. Tracks the number of coins left in each tube.
// Ports:
//   clk, rst          clock (posedge); synchronous active-high reset
//   req_valid/ready   request handshake; req_change is the amount
//   refill            reload both tubes (taken only while idle)
//   drop_sense        coin-drop sensor (confirm build only)
//   eject5, eject10   solenoid drives
//   busy, done, err   status; done is a one-cycle pulse, err holds until the next accept
//   inv5, inv10, low  tube counts and the low-inventory flag
// Build option: define COIN_PAYOUT_CONFIRM_EN to wait for drop_sense after
// every pulse, with a CONFIRM_TO-cycle timeout.
module coin_payout #(
  parameter int PULSE_CYC  = 4,
  parameter int GAP_CYC    = 4,
  parameter int INV_W      = 8,
  parameter int INV_INIT5  = 20,
  parameter int INV_INIT10 = 20,
  parameter int CONFIRM_TO = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_change,
  input  logic             refill,
  input  logic             drop_sense,
  output logic             eject5,
  output logic             eject10,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [INV_W-1:0] inv5,
  output logic [INV_W-1:0] inv10,
  output logic             low
);

  // One shared timer covers pulse, gap and confirm windows.
  localparam int TM1  = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int TMAX = (TM1 > CONFIRM_TO) ? TM1 : CONFIRM_TO;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAN,
    S_PULSE,
`ifdef COIN_PAYOUT_CONFIRM_EN
    S_WAIT_DROP,
`endif
    S_GAP,
    S_DONE
  } state_t;

  state_t          state, nstate;
  logic [TW-1:0]   tmr;
  logic [1:0]      amt;
  logic            cnt10;     // 10 Rs coins still to pay (after the current one)
  logic [1:0]      cnt5;      // 5 Rs coins still to pay
  logic            cur10;     // coin being ejected is 10 Rs
  logic            err_q;
  logic [INV_W-1:0] inv5_q, inv10_q;

  logic            accept;
  logic            p_fail, p10;
  logic [1:0]      p5;
  logic            src10;
  logic [1:0]      src5;
  logic            more;
  logic            set_err;

  assign accept = req_valid && (state == S_IDLE);

  // Coin plan for the latched amount against current inventory.
  always_comb begin
    p_fail = 1'b0;
    p10    = 1'b0;
    p5     = 2'd0;
    case (amt)
      2'd1: begin
        if (inv5_q != '0) p5 = 2'd1;
        else              p_fail = 1'b1;
      end
      2'd2: begin
        if (inv10_q != '0)             p10 = 1'b1;
        else if (inv5_q >= INV_W'(2))  p5  = 2'd2;
        else                           p_fail = 1'b1;
      end
      2'd3: begin
        if (inv10_q != '0 && inv5_q != '0) begin
          p10 = 1'b1;
          p5  = 2'd1;
        end else if (inv5_q >= INV_W'(3)) p5 = 2'd3;
        else                              p_fail = 1'b1;
      end
      default: ;
    endcase
  end

  // Coins outstanding when choosing the next one: fresh plan or remainder.
  always_comb begin
    src10 = cnt10;
    src5  = cnt5;
    if (state == S_PLAN) begin
      src10 = p10;
      src5  = p5;
    end
  end
  assign more = src10 || (src5 != 2'd0);

  always_comb begin
    nstate  = state;
    set_err = 1'b0;
    case (state)
      S_IDLE:  if (accept) nstate = S_PLAN;
      S_PLAN: begin
        if (amt == 2'd0 || p_fail) begin
          nstate  = S_DONE;
          set_err = p_fail;
        end else begin
          nstate = S_PULSE;
        end
      end
      S_PULSE: begin
        if (tmr == TW'(PULSE_CYC - 1)) begin
`ifdef COIN_PAYOUT_CONFIRM_EN
          nstate = S_WAIT_DROP;
`else
          nstate = S_GAP;
`endif
        end
      end
`ifdef COIN_PAYOUT_CONFIRM_EN
      S_WAIT_DROP: begin
        if (drop_sense) begin
          nstate = S_GAP;
        end else if (tmr == TW'(CONFIRM_TO - 1)) begin
          nstate  = S_DONE;
          set_err = 1'b1;
        end
      end
`endif
      S_GAP:   if (tmr == TW'(GAP_CYC - 1)) nstate = more ? S_PULSE : S_DONE;
      S_DONE:  nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      tmr     <= '0;
      amt     <= 2'd0;
      cnt10   <= 1'b0;
      cnt5    <= 2'd0;
      cur10   <= 1'b0;
      err_q   <= 1'b0;
      inv5_q  <= INV_W'(INV_INIT5);
      inv10_q <= INV_W'(INV_INIT10);
    end else begin
      state <= nstate;
      if (nstate != state || state == S_IDLE) tmr <= '0;
      else                                    tmr <= tmr + 1'b1;

      if (accept) begin
        amt   <= req_change;
        err_q <= 1'b0;
      end
      if (set_err) err_q <= 1'b1;

      // Refill lands at the accept edge, so PLAN sees the reloaded counts.
      if (state == S_IDLE && refill) begin
        inv5_q  <= INV_W'(INV_INIT5);
        inv10_q <= INV_W'(INV_INIT10);
      end

      // Entering a pulse: pick the coin (10 Rs first) and consume it from the plan.
      if (nstate == S_PULSE && state != S_PULSE) begin
        cur10 <= src10;
        cnt10 <= 1'b0;
        cnt5  <= src10 ? src5 : src5 - 2'd1;
      end

      if (state == S_PULSE && tmr == '0) begin
        if (cur10) inv10_q <= inv10_q - 1'b1;
        else       inv5_q  <= inv5_q - 1'b1;
      end
    end
  end

`ifndef COIN_PAYOUT_CONFIRM_EN
  logic unused_drop;
  assign unused_drop = drop_sense;
`endif

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign eject10   = (state == S_PULSE) &&  cur10;
  assign eject5    = (state == S_PULSE) && !cur10;
  assign err       = err_q;
  assign inv5      = inv5_q;
  assign inv10     = inv10_q;
  assign low       = (inv5_q == '0) || (inv10_q == '0);

endmodule

// File: tb/tb_coin_payout.sv
module tb_coin_payout;
`ifdef COIN_PAYOUT_CONFIRM_EN
  localparam int W = 1;   // one WAIT_DROP cycle per coin with drop_sense high
`else
  localparam int W = 0;
`endif

  logic       clk = 0, rst = 1;
  logic       req_valid = 0, refill = 0, drop_sense = 1;
  logic [1:0] req_change = 0;
  logic       req_ready, eject5, eject10, busy, done, err, low;
  logic [7:0] inv5, inv10;

  int checks = 0, failures = 0;

  coin_payout dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_change(req_change), .refill(refill), .drop_sense(drop_sense),
    .eject5(eject5), .eject10(eject10), .busy(busy), .done(done), .err(err),
    .inv5(inv5), .inv10(inv10), .low(low)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pulse_at(input int start);
    logic [63:0] m;
    m = 64'hF;
    return m << start;
  endfunction

  logic [63:0] e5_map, e10_map;
  int          done_c;
  logic        both_seen, err_at_done;

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  // Issue one request; cycle 0 is the accept cycle. Records eject maps per cycle.
  task automatic run_req(input logic [1:0] ch, input bit rf_accept, input int rf_mid);
    int n;
    n = 0;
    e5_map = '0; e10_map = '0; done_c = -1; both_seen = 0; err_at_done = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    req_valid = 1; req_change = ch; refill = rf_accept;
    @(posedge clk);
    #1 req_valid = 0; refill = 0;
    for (int c = 1; c < 60; c++) begin
      @(negedge clk);
      e5_map[c]  = eject5;
      e10_map[c] = eject10;
      if (eject5 && eject10) both_seen = 1;
      refill = (c == rf_mid);
      if (done) begin
        done_c = c;
        err_at_done = err;
        break;
      end
    end
    refill = 0;
    if (done_c < 0) chk("done_timeout", 0, 1);
    @(negedge clk);
    chk("ready_after_done", req_ready, 1);
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_eject5", eject5, 0);
    chk("rst_eject10", eject10, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_inv5", inv5, 20);
    chk("rst_inv10", inv10, 20);
    chk("rst_low", low, 0);

    // T1: single 5 Rs
    run_req(2'b01, 0, -1);
    chk("t1_e5", e5_map, pulse_at(2));
    chk("t1_e10", e10_map, 0);
    chk("t1_done", done_c, 10 + W);
    chk("t1_err", err_at_done, 0);
    chk("t1_inv5", inv5, 19);
    chk("t1_inv10", inv10, 20);

    // T2: 15 Rs as 10 then 5
    run_req(2'b11, 0, -1);
    chk("t2_e10", e10_map, pulse_at(2));
    chk("t2_e5", e5_map, pulse_at(10 + W));
    chk("t2_done", done_c, 18 + 2 * W);
    chk("t2_both", both_seen, 0);
    chk("t2_inv5", inv5, 18);
    chk("t2_inv10", inv10, 19);

    // Drain the 10 Rs tube
    for (int i = 0; i < 19; i++) run_req(2'b10, 0, -1);
    chk("drain_inv10", inv10, 0);
    chk("drain_low", low, 1);

    // T3: 10 Rs paid as two 5 Rs
    run_req(2'b10, 0, -1);
    chk("t3_e5", e5_map, pulse_at(2) | pulse_at(10 + W));
    chk("t3_e10", e10_map, 0);
    chk("t3_done", done_c, 18 + 2 * W);
    chk("t3_err", err_at_done, 0);
    chk("t3_inv5", inv5, 16);

    for (int i = 0; i < 14; i++) run_req(2'b01, 0, -1);
    chk("drain_inv5", inv5, 2);

    // T4: 15 Rs with inv10=0, inv5=2 fails
    run_req(2'b11, 0, -1);
    chk("t4_e5", e5_map, 0);
    chk("t4_e10", e10_map, 0);
    chk("t4_done", done_c, 2);
    chk("t4_err", err_at_done, 1);
    chk("t4_inv5", inv5, 2);
    chk("t4_inv10", inv10, 0);
    repeat (3) @(negedge clk);
    chk("t4_err_held", err, 1);

    // Refill with accept: PLAN sees 20/20; refill mid-payout is ignored
    run_req(2'b11, 1, 3);
    chk("rf_e10", e10_map, pulse_at(2));
    chk("rf_e5", e5_map, pulse_at(10 + W));
    chk("rf_err_cleared", err_at_done, 0);
    chk("rf_inv5", inv5, 19);
    chk("rf_inv10", inv10, 19);

    // 00 request: straight to done, no error
    run_req(2'b00, 0, -1);
    chk("zero_done", done_c, 2);
    chk("zero_eject", e5_map | e10_map, 0);
    chk("zero_err", err_at_done, 0);

    // T5: reset during second pulse
    do_reset();
    @(negedge clk);
    req_valid = 1; req_change = 2'b11;
    @(posedge clk);
    #1 req_valid = 0;
    repeat (12) @(negedge clk);
    chk("t5_mid_e5", eject5, 1);
    chk("t5_mid_inv5", inv5, 19);
    chk("t5_mid_inv10", inv10, 19);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("t5_e5", eject5, 0);
    chk("t5_e10", eject10, 0);
    chk("t5_inv5", inv5, 20);
    chk("t5_inv10", inv10, 20);
    chk("t5_ready", req_ready, 1);
    chk("t5_busy", busy, 0);

`ifdef COIN_PAYOUT_CONFIRM_EN
    // T6: no drop confirm after first coin -> timeout, second coin abandoned
    drop_sense = 0;
    run_req(2'b11, 0, -1);
    chk("t6_e10", e10_map, pulse_at(2));
    chk("t6_e5", e5_map, 0);
    chk("t6_done", done_c, 22);
    chk("t6_err", err_at_done, 1);
    chk("t6_inv10", inv10, 19);
    chk("t6_inv5", inv5, 20);
    drop_sense = 1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
